// File: rtl/uart_line_buffer.sv
// -----------------------------------------------------------------------------
// uart_line_buffer
//
// Buffers console bytes in a circular FIFO and releases them to a consumer
// a whole line at a time. A line ends with 0x0A. If the input goes quiet for
// TIMEOUT cycles while a partial line sits in the FIFO, the bytes present at
// that moment are released as one "flush window".
//
// Parameters
//   DEPTH    FIFO byte capacity (power of 2, >= 4)
//   TIMEOUT  quiet cycles before a partial line is flushed (>= 2)
//
// Ports
//   clock       rising-edge clock
//   reset       synchronous, active-high reset
//   in_valid    console byte present this cycle (no backpressure)
//   in_ch       console byte
//   out_valid   out_ch holds a byte ready for transfer
//   out_ready   consumer accepts; transfer when out_valid && out_ready
//   out_ch      FIFO head byte
//   out_last    out_ch ends a line or a flush window
//   level       current FIFO occupancy
//   drop_count  number of dropped input bytes, saturating at 0xFFFF
//   overflow    sticky, set on the first dropped byte
// -----------------------------------------------------------------------------
module uart_line_buffer #(
    parameter int DEPTH   = 64,
    parameter int TIMEOUT = 1000
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [7:0]               in_ch,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [7:0]               out_ch,
    output logic                     out_last,
    output logic [$clog2(DEPTH):0]   level,
    output logic [15:0]              drop_count,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(TIMEOUT + 1);

    localparam logic [7:0]    NEWLINE   = 8'h0A;
    localparam logic [AW:0]   DEPTH_L   = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   ONE_L     = (AW + 1)'(1);
    localparam logic [CW-1:0] TIMEOUT_L = CW'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LINE  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t        state_reg, state_next;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]   wr_ptr_reg;
    logic [AW:0]   rd_ptr_reg;
    logic [AW:0]   rd_ptr_next;
    logic [AW:0]   lines_pending_reg, lines_pending_next;
    logic [AW:0]   flush_rem_reg, flush_rem_next;
    logic [CW-1:0] idle_cnt_reg;
    logic [15:0]   drop_count_reg;
    logic          overflow_reg;

    logic [7:0]    mem [DEPTH];
    logic [7:0]    head_reg;

    logic          pop;
    logic          push;
    logic          drop;
    logic          head_fwd;

    // ------------------------------------------------------------------
    // Handshake and occupancy
    // ------------------------------------------------------------------
    assign level     = wr_ptr_reg - rd_ptr_reg;
    assign out_valid = ((state_reg == LINE) || (state_reg == FLUSH)) && (level != '0);
    assign pop       = out_valid && out_ready;
    // A full FIFO still takes a byte when the head leaves in the same cycle.
    assign push      = in_valid && ((level != DEPTH_L) || pop);
    assign drop      = in_valid && !push;

    assign rd_ptr_next = rd_ptr_reg + {{AW{1'b0}}, pop};

    // The head register is a registered read of the location that will be
    // the head after this edge. If that location is being written right now
    // (empty FIFO receiving its first byte), forward the incoming byte since
    // the array still holds stale data for this edge.
    assign head_fwd = push && (wr_ptr_reg[AW-1:0] == rd_ptr_next[AW-1:0]);

    assign out_ch   = head_reg;
    assign out_last = ((state_reg == LINE)  && (head_reg == NEWLINE)) ||
                      ((state_reg == FLUSH) && (flush_rem_reg == ONE_L));

    assign drop_count = drop_count_reg;
    assign overflow   = overflow_reg;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (push && !reset) begin
            mem[wr_ptr_reg[AW-1:0]] <= in_ch;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head_reg <= '0;
        end else if (head_fwd) begin
            head_reg <= in_ch;
        end else begin
            head_reg <= mem[rd_ptr_next[AW-1:0]];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + ONE_L;
            end
            rd_ptr_reg <= rd_ptr_next;
        end
    end

    // ------------------------------------------------------------------
    // Newline bookkeeping: count of 0x0A bytes currently in the FIFO
    // ------------------------------------------------------------------
    always_comb begin
        lines_pending_next = lines_pending_reg;
        case ({push && (in_ch == NEWLINE), pop && (head_reg == NEWLINE)})
            2'b10:   lines_pending_next = lines_pending_reg + ONE_L;
            2'b01:   lines_pending_next = lines_pending_reg - ONE_L;
            default: lines_pending_next = lines_pending_reg;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            lines_pending_reg <= '0;
        end else begin
            lines_pending_reg <= lines_pending_next;
        end
    end

    // ------------------------------------------------------------------
    // Quiet-time counter, drop counter, overflow flag
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            idle_cnt_reg <= '0;
        end else if (in_valid) begin
            idle_cnt_reg <= '0;
        end else if (idle_cnt_reg != TIMEOUT_L) begin
            idle_cnt_reg <= idle_cnt_reg + CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            drop_count_reg <= '0;
            overflow_reg   <= 1'b0;
        end else if (drop) begin
            if (drop_count_reg != 16'hFFFF) begin
                drop_count_reg <= drop_count_reg + 16'd1;
            end
            overflow_reg <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Release FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= IDLE;
            flush_rem_reg <= '0;
        end else begin
            state_reg     <= state_next;
            flush_rem_reg <= flush_rem_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        flush_rem_next = flush_rem_reg;
        case (state_reg)
            IDLE: begin
                // Complete lines win over a pending timeout flush.
                if (lines_pending_reg != '0) begin
                    state_next = LINE;
                end else if ((level != '0) && (idle_cnt_reg == TIMEOUT_L)) begin
                    // The window covers only bytes present now; later
                    // arrivals wait for their own line end or timeout.
                    state_next     = FLUSH;
                    flush_rem_next = level;
                end
            end
            LINE: begin
                if (pop && (head_reg == NEWLINE)) begin
                    state_next = IDLE;
                end
            end
            FLUSH: begin
                if (pop) begin
                    flush_rem_next = flush_rem_reg - ONE_L;
                    if (flush_rem_reg == ONE_L) begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_line_buffer.sv
// -----------------------------------------------------------------------------
// tb_uart_line_buffer
//
// Directed scenarios against a queue-based model of the line buffer. A
// compare process checks the DUT against the model on every falling edge;
// directed literal checks pin the model and the scenario outcomes.
// -----------------------------------------------------------------------------
module tb_uart_line_buffer;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 8;

    logic                   clock = 1'b0;
    logic                   reset;
    logic                   in_valid;
    logic [7:0]             in_ch;
    logic                   out_valid;
    logic                   out_ready;
    logic [7:0]             out_ch;
    logic                   out_last;
    logic [$clog2(DEPTH):0] level;
    logic [15:0]            drop_count;
    logic                   overflow;

    uart_line_buffer #(
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ch      (in_ch),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_ch     (out_ch),
        .out_last   (out_last),
        .level      (level),
        .drop_count (drop_count),
        .overflow   (overflow)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    // Model state: FIFO contents as a queue, release mode, window size.
    logic [7:0] mq[$];
    int         m_mode;   // 0 = waiting, 1 = releasing a line, 2 = flushing
    int         m_win;
    int         m_idle;
    int         m_drops;
    bit         m_ovf;

    // Transfers observed on the DUT output port.
    logic [7:0] xf_ch[$];
    bit         xf_last[$];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int nl_count();
        int n = 0;
        foreach (mq[i]) if (mq[i] == 8'h0A) n++;
        return n;
    endfunction

    // One clock: the model consumes the inputs sampled at the rising edge.
    task automatic step();
        bit         pop;
        bit         acc;
        logic [7:0] b;
        int         nl;
        @(posedge clock);
        if (reset) begin
            mq.delete();
            m_mode  = 0;
            m_win   = 0;
            m_idle  = 0;
            m_drops = 0;
            m_ovf   = 1'b0;
        end else begin
            pop = (m_mode != 0) && (mq.size() > 0) && out_ready;
            b   = pop ? mq[0] : 8'h00;
            acc = in_valid && ((mq.size() < DEPTH) || pop);
            nl  = nl_count();
            case (m_mode)
                0: begin
                    if (nl > 0) m_mode = 1;
                    else if (mq.size() > 0 && m_idle == TIMEOUT) begin
                        m_mode = 2;
                        m_win  = mq.size();
                    end
                end
                1: if (pop && b == 8'h0A) m_mode = 0;
                default: begin
                    if (pop) begin
                        m_win--;
                        if (m_win == 0) m_mode = 0;
                    end
                end
            endcase
            if (pop) void'(mq.pop_front());
            if (acc) mq.push_back(in_ch);
            if (in_valid && !acc) begin
                if (m_drops < 65535) m_drops++;
                m_ovf = 1'b1;
            end
            if (in_valid) m_idle = 0;
            else if (m_idle < TIMEOUT) m_idle++;
        end
        @(negedge clock);
    endtask

    task automatic push_byte(logic [7:0] ch);
        in_valid = 1'b1;
        in_ch    = ch;
        step();
        in_valid = 1'b0;
    endtask

    task automatic idle(int n);
        repeat (n) step();
    endtask

    task automatic clear_xf();
        xf_ch.delete();
        xf_last.delete();
    endtask

    task automatic expect_xf(string name, int i, logic [7:0] ch, bit last);
        if (i < xf_ch.size()) begin
            chk({name, "_ch"}, 32'(xf_ch[i]), 32'(ch));
            chk({name, "_last"}, 32'(xf_last[i]), 32'(last));
        end
    endtask

    always @(posedge clock) begin
        if (!reset && out_valid && out_ready) begin
            xf_ch.push_back(out_ch);
            xf_last.push_back(out_last);
            $display("xfer: ch=0x%02h last=%0d level=%0d", out_ch, out_last, level);
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clock) begin
        bit exp_v;
        if (cmp_en) begin
            exp_v = (m_mode != 0) && (mq.size() > 0);
            chk("m_out_valid", 32'(out_valid), 32'(exp_v));
            chk("m_level", 32'(level), 32'(mq.size()));
            chk("m_drop_count", 32'(drop_count), 32'(m_drops));
            chk("m_overflow", 32'(overflow), 32'(m_ovf));
            if (exp_v) begin
                chk("m_out_ch", 32'(out_ch), 32'(mq[0]));
                chk("m_out_last", 32'(out_last),
                    32'((m_mode == 1 && mq[0] == 8'h0A) || (m_mode == 2 && m_win == 1)));
            end
        end
    end

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b1;     // must be ignored while in reset
        in_ch     = 8'h0A;
        out_ready = 1'b1;
        step();
        cmp_en = 1'b1;
        step();
        step();
        reset    = 1'b0;
        in_valid = 1'b0;
        idle(3);
        chk("reset_level", 32'(level), 32'd0);
        chk("reset_drop_count", 32'(drop_count), 32'd0);
        chk("reset_overflow", 32'(overflow), 32'd0);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_last", 32'(out_last), 32'd0);

        // "hi\n" with the consumer always ready.
        clear_xf();
        out_ready = 1'b1;
        push_byte(8'h68);
        push_byte(8'h69);
        push_byte(8'h0A);
        chk("hi_valid_at_k", 32'(out_valid), 32'd0);
        chk("hi_level_at_k", 32'(level), 32'd3);
        step();
        chk("hi_valid_at_k1", 32'(out_valid), 32'd1);
        chk("hi_first_ch", 32'(out_ch), 32'h68);
        idle(6);
        chk("hi_count", 32'(xf_ch.size()), 32'd3);
        expect_xf("hi0", 0, 8'h68, 1'b0);
        expect_xf("hi1", 1, 8'h69, 1'b0);
        expect_xf("hi2", 2, 8'h0A, 1'b1);
        chk("hi_level_end", 32'(level), 32'd0);

        // "ab" then silence: one timeout flush, then nothing more.
        clear_xf();
        push_byte(8'h61);
        push_byte(8'h62);
        idle(TIMEOUT);
        chk("flush_not_early", 32'(xf_ch.size()), 32'd0);
        idle(60);
        chk("flush_count", 32'(xf_ch.size()), 32'd2);
        expect_xf("flush0", 0, 8'h61, 1'b0);
        expect_xf("flush1", 1, 8'h62, 1'b1);
        chk("flush_level_end", 32'(level), 32'd0);

        // Overflow: six bytes into a four-byte FIFO with no consumer.
        clear_xf();
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) push_byte(8'h41 + 8'(i));
        chk("ovf_level", 32'(level), 32'd4);
        chk("ovf_drop_count", 32'(drop_count), 32'd2);
        chk("ovf_flag", 32'(overflow), 32'd1);
        out_ready = 1'b1;
        idle(30);
        chk("ovf_drained_level", 32'(level), 32'd0);
        chk("ovf_sticky", 32'(overflow), 32'd1);
        chk("ovf_count", 32'(xf_ch.size()), 32'd4);
        expect_xf("ovf0", 0, 8'h41, 1'b0);
        expect_xf("ovf3", 3, 8'h44, 1'b1);

        // "xyz\n" released under a stalling consumer.
        clear_xf();
        out_ready = 1'b0;
        push_byte(8'h78);
        push_byte(8'h79);
        push_byte(8'h7A);
        push_byte(8'h0A);
        for (int i = 0; i < 18; i++) begin
            out_ready = (i % 3 == 0);
            step();
        end
        out_ready = 1'b1;
        chk("stall_count", 32'(xf_ch.size()), 32'd4);
        expect_xf("stall0", 0, 8'h78, 1'b0);
        expect_xf("stall1", 1, 8'h79, 1'b0);
        expect_xf("stall2", 2, 8'h7A, 1'b0);
        expect_xf("stall3", 3, 8'h0A, 1'b1);

        // Full FIFO in LINE: simultaneous push and transfer.
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst2_drop_count", 32'(drop_count), 32'd0);
        chk("rst2_overflow", 32'(overflow), 32'd0);
        clear_xf();
        out_ready = 1'b0;
        push_byte(8'h73);
        push_byte(8'h74);
        push_byte(8'h0A);
        push_byte(8'h75);
        chk("full_level", 32'(level), 32'd4);
        out_ready = 1'b1;
        push_byte(8'h76);
        chk("full_swap_level", 32'(level), 32'd4);
        chk("full_swap_drops", 32'(drop_count), 32'd0);
        idle(40);
        chk("full_count", 32'(xf_ch.size()), 32'd5);
        expect_xf("full0", 0, 8'h73, 1'b0);
        expect_xf("full2", 2, 8'h0A, 1'b1);
        expect_xf("full3", 3, 8'h75, 1'b0);
        expect_xf("full4", 4, 8'h76, 1'b1);

        // Reset in the middle of a line.
        clear_xf();
        out_ready = 1'b0;
        push_byte(8'h6D);
        push_byte(8'h6E);
        push_byte(8'h0A);
        idle(2);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_level", 32'(level), 32'd0);
        chk("midrst_out_last", 32'(out_last), 32'd0);
        out_ready = 1'b1;
        push_byte(8'h6B);
        push_byte(8'h0A);
        idle(6);
        chk("midrst_count", 32'(xf_ch.size()), 32'd3);
        expect_xf("midrst0", 0, 8'h6D, 1'b0);
        expect_xf("midrst1", 1, 8'h6B, 1'b0);
        expect_xf("midrst2", 2, 8'h0A, 1'b1);

        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_line_buffer.md
UART_LINE_BUFFER -- requirements
Module: uart_line_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 64, meaning FIFO byte capacity (power of 2, >=4).
REQ-002 SHALL have parameter TIMEOUT, default 1000, meaning the quiet cycles before a partial line is flushed (>=2).
REQ-003 SHALL have port clock  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  a console byte is present this cycle; there is no backpressure.
REQ-006 SHALL have port in_ch  input  8  console byte, sampled when in_valid=1.
REQ-007 SHALL have port out_valid  output  1  out_ch holds a byte ready for transfer.
REQ-008 SHALL have port out_ready  input  1  consumer accepts the byte; transfer when out_valid && out_ready.
REQ-009 SHALL have port out_ch  output  8  FIFO head byte.
REQ-010 SHALL have port out_last  output  1  out_ch is the last byte of a line or of a flush window.
REQ-011 SHALL have port level  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-012 SHALL have port drop_count  output  16  count of dropped input bytes, saturating at 0xFFFF.
REQ-013 SHALL have port overflow  output  1  sticky flag, set on the first dropped byte.

Function
REQ-014 SHALL implement a circular FIFO with wrapping read/write pointers; level = writes - reads.
REQ-015 SHALL accept in_ch on in_valid if level<DEPTH, or if level==DEPTH and a transfer occurs the same cycle (level unchanged).
REQ-016 SHALL otherwise drop the byte, increment drop_count (saturating), and set overflow; a dropped 0x0A is not counted as a line.
REQ-017 SHALL maintain lines_pending = number of 0x0A bytes in the FIFO; it SHALL increment on accepted 0x0A and decrement on transferred 0x0A, with simultaneous increment and decrement leaving it unchanged.
REQ-018 SHALL maintain idle_cnt: cleared on any in_valid (accepted or dropped), otherwise incremented, saturating at TIMEOUT.
REQ-019 SHALL have a registered FSM with states IDLE, LINE, and FLUSH.
REQ-020 IDLE->LINE SHALL occur when lines_pending>0; LINE has priority over FLUSH.
REQ-021 IDLE->FLUSH SHALL occur when lines_pending==0, level>0, and idle_cnt==TIMEOUT; on entry, flush_rem SHALL be loaded with level.
REQ-022 LINE->IDLE SHALL occur on transfer of a 0x0A byte.
REQ-023 FLUSH->IDLE SHALL occur on transfer when flush_rem==1; each FLUSH transfer SHALL decrement flush_rem; bytes arriving during FLUSH are enqueued but are outside the window.
REQ-024 out_valid SHALL be (state==LINE || state==FLUSH) && level>0.
REQ-025 out_ch SHALL be the FIFO head byte.
REQ-026 out_last SHALL be (LINE && out_ch==0x0A) || (FLUSH && flush_rem==1).
REQ-027 Latency: a 0x0A accepted at edge k SHALL raise lines_pending at edge k, the state SHALL become LINE at edge k+1, and out_valid SHALL be high after edge k+1 if the state was IDLE.
REQ-028 While out_valid && !out_ready, out_ch and out_last SHALL hold stable.
REQ-029 A flush SHALL fire only once per quiet period; the FIFO is empty afterward and no re-flush occurs until new input clears idle_cnt and the timeout elapses again.

Reset
REQ-030 On reset the block SHALL go to state IDLE, set pointers, level, lines_pending, flush_rem, idle_cnt, drop_count, and overflow to 0, and drive out_valid=0 and out_last=0 from the next edge; reset SHALL abort any LINE or FLUSH in progress and discard FIFO contents.
REQ-031 in_valid asserted during reset SHALL be ignored and not counted.

Verification
REQ-032 Scenario: push "hi\n" (0x68,0x69,0x0A) on consecutive cycles with out_ready=1 -> out_ch 0x68,0x69,0x0A; out_last only on 0x0A; first out_valid one edge after the 0x0A is accepted; level returns to 0.
REQ-033 Scenario: TIMEOUT=8, push "ab", then idle -> after 8 quiet cycles, FLUSH emits 0x61,0x62 with out_last on 0x62; no further out_valid over 50 idle cycles.
REQ-034 Scenario: DEPTH=4, out_ready=0, push 6 non-newline bytes -> level=4, drop_count=2, overflow=1; overflow stays 1 after the FIFO drains.
REQ-035 Scenario: line "xyz\n" buffered with out_ready toggling 1,0,0,1,... -> out_ch stable across stalls; bytes in order; exactly 4 transfers.
REQ-036 Scenario: DEPTH=4, FIFO full in LINE, in_valid and transfer on the same cycle -> byte accepted, level stays 4, drop_count unchanged.
REQ-037 Scenario: reset asserted mid-LINE after 1 of 3 bytes transferred -> next cycle out_valid=0, level=0, state IDLE; subsequent "k\n" is emitted correctly.
